// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl
//   Execution controller for the TD4 4-bit CPU core. It produces the core's
//   one-clock execute pulse (cpu_ce). Three modes are supported: free-run at
//   a programmable rate, single-step from a debounced push-button, and halt
//   when the PC matches a breakpoint.
//
// Ports
//   clock     in   system clock, all logic on the rising edge
//   reset     in   synchronous active-high reset, clears all state
//   run_sw    in   1 = request free-run, 0 = stop/step mode
//   step_btn  in   raw asynchronous push-button (active-high, may bounce)
//   div_val   in   free-run period in clocks (0 behaves as 1)
//   bp_en     in   breakpoint enable
//   bp_addr   in   breakpoint PC
//   pc        in   current PC from the core (address of next instruction)
//   cpu_ce    out  registered one-clock execute pulse
//   state     out  00 STOP, 01 RUN, 10 BRK
//   halted    out  high while in BRK
//   step_cnt  out  number of cpu_ce pulses issued, wraps at 256
module td4_run_ctrl #(
    parameter int DIV_W      = 24,
    parameter int DEB_CYCLES = 16,
    parameter int PC_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div_val,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [7:0]       step_cnt
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_BRK  = 2'b10
    } run_state_t;

    // ------------------------------------------------------------------
    // Button path: 2-FF synchroniser, debounce, registered rising edge.
    // ------------------------------------------------------------------
    logic             btn_meta;
    logic             btn_sync;
    logic             deb_level;
    logic             deb_prev;
    logic             step_ev;
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            step_ev   <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_meta <= step_btn;
            btn_sync <= btn_meta;
            deb_prev <= deb_level;
            // Edge detect is registered so the button-to-cpu_ce latency
            // is a fixed DEB_CYCLES+3 clocks.
            step_ev  <= deb_level & ~deb_prev;
            if (btn_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= btn_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    run_state_t       cur_state;
    run_state_t       nxt_state;
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] count_nxt;
    logic             skip_bp;
    logic             skip_nxt;
    logic             ce_nxt;
    logic [DIV_W-1:0] div_last;
    logic             tick;
    logic             bp_hit;

    assign div_last = (div_val == '0) ? '0 : (div_val - 1'b1);
    // ">=" rather than "==" so a period shortened mid-run still ticks.
    assign tick     = (count >= div_last);
    assign bp_hit   = bp_en && (pc == bp_addr) && !skip_bp;

    always_comb begin
        nxt_state = cur_state;
        count_nxt = count;
        skip_nxt  = skip_bp;
        ce_nxt    = 1'b0;
        unique case (cur_state)
            ST_STOP: begin
                if (run_sw) begin
                    nxt_state = ST_RUN;
                    count_nxt = '0;
                    skip_nxt  = 1'b1;
                end else if (step_ev) begin
                    ce_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_sw) begin
                    nxt_state = ST_STOP;
                    count_nxt = '0;
                end else if (tick) begin
                    count_nxt = '0;
                    if (bp_hit) begin
                        nxt_state = ST_BRK;
                    end else begin
                        ce_nxt   = 1'b1;
                        skip_nxt = 1'b0;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            ST_BRK: begin
                if (step_ev) begin
                    ce_nxt = 1'b1;
                end
                if (!run_sw) begin
                    nxt_state = ST_STOP;
                end
            end
            default: begin
                nxt_state = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= ST_STOP;
            count     <= '0;
            skip_bp   <= 1'b0;
            cpu_ce    <= 1'b0;
            step_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            count     <= count_nxt;
            skip_bp   <= skip_nxt;
            cpu_ce    <= ce_nxt;
            step_cnt  <= step_cnt + {7'd0, cpu_ce};
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == ST_BRK);

endmodule
